mem_arbiter: RTL and testbench



---
 rtl/mem_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin N-channel controller for one single-ported synchronous memory and I/O bus
module mem_arbiter #(
    parameter int N_CH       = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_CH-1:0]              req_valid,
    input  logic [N_CH-1:0]              req_we,
    input  logic [2*N_CH-1:0]            req_size,
    input  logic [N_CH-1:0]              req_signed,
    input  logic [N_CH*ADDR_WIDTH-1:0]   req_addr,
    input  logic [N_CH*DATA_WIDTH-1:0]   req_wdata,
    input  logic [N_CH-1:0]              flush,
    output logic [N_CH-1:0]              resp_done,
    output logic [CH_W-1:0]              resp_id,
    output logic [DATA_WIDTH-1:0]        resp_data,
    output logic                         resp_err,
    output logic [ADDR_WIDTH-1:0]        mem_addr,
    output logic                         mem_we,
    output logic [DATA_WIDTH-1:0]        mem_wdata,
    input  logic [DATA_WIDTH-1:0]        mem_rdata
);
    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WRITE, S_DONE} state_t;
    localparam logic [N_CH-1:0] L_ONE = {{(N_CH-1){1'b0}}, 1'b1};

    state_t                r_state, w_next;
    logic [CH_W-1:0]       r_ptr, r_id;
    logic                  r_we, r_signed, r_cancel, r_io;
    logic [1:0]            r_size, r_off;
    logic [DATA_WIDTH-1:0] r_wdata;

    logic [ADDR_WIDTH-1:0] w_addr_a [N_CH];
    logic [DATA_WIDTH-1:0] w_wdata_a [N_CH];
    logic [1:0]            w_size_a [N_CH];
    logic [N_CH-1:0]       w_elig;
    logic                  w_found, w_hi_f;
    logic [CH_W-1:0]       w_hi, w_lo, w_gnt;
    logic [ADDR_WIDTH-1:0] w_g_addr;
    logic [DATA_WIDTH-1:0] w_g_wdata;
    logic [1:0]            w_g_size;
    logic                  w_g_err, w_g_direct, w_r_direct, w_cancel;
    logic [4:0]            w_sh;
    logic [DATA_WIDTH-1:0] w_rsh, w_load, w_mask, w_merge;

    logic                  w_o_we, w_o_err;
    logic [ADDR_WIDTH-1:0] w_o_addr;
    logic [DATA_WIDTH-1:0] w_o_wdata, w_o_data;
    logic [N_CH-1:0]       w_o_done;
    logic [CH_W-1:0]       w_o_id;

    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            w_addr_a[c]  = req_addr[c*ADDR_WIDTH +: ADDR_WIDTH];
            w_wdata_a[c] = req_wdata[c*DATA_WIDTH +: DATA_WIDTH];
            w_size_a[c]  = req_size[2*c +: 2];
        end
    end

    // Round robin: lowest eligible channel at or above r_ptr, else lowest eligible overall.
    always_comb begin
        w_elig  = req_valid & ~flush;
        w_found = |w_elig;
        w_hi_f  = 1'b0;
        w_hi    = '0;
        w_lo    = '0;
        for (int c = N_CH-1; c >= 0; c--) begin
            if (w_elig[c]) begin
                w_lo = CH_W'(c);
                if (CH_W'(c) >= r_ptr) begin
                    w_hi   = CH_W'(c);
                    w_hi_f = 1'b1;
                end
            end
        end
        w_gnt = w_hi_f ? w_hi : w_lo;
    end

    assign w_g_addr   = w_addr_a[w_gnt];
    assign w_g_wdata  = w_wdata_a[w_gnt];
    assign w_g_size   = w_size_a[w_gnt];
    assign w_g_err    = (w_g_size == 2'b11) || (w_g_size == 2'b01 && w_g_addr[0]) ||
                        (w_g_size == 2'b10 && w_g_addr[1:0] != 2'b00);
    assign w_g_direct = (w_g_size == 2'b10) || (w_g_addr[17:16] == 2'b11);
    assign w_r_direct = (r_size == 2'b10) || r_io;
    assign w_cancel   = r_cancel | flush[r_id];

    assign w_sh    = {r_off, 3'b000};
    assign w_rsh   = mem_rdata >> w_sh;
    assign w_mask  = ((r_size == 2'b00) ? 32'h0000_00FF : 32'h0000_FFFF) << w_sh;
    assign w_merge = (mem_rdata & ~w_mask) | ((r_wdata << w_sh) & w_mask);

    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{r_signed & w_rsh[7]}}, w_rsh[7:0]};
            2'b01:   w_load = {{16{r_signed & w_rsh[15]}}, w_rsh[15:0]};
            default: w_load = w_rsh;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_found) w_next = w_g_err ? S_DONE : S_ISSUE;
            S_ISSUE: w_next = (r_we && w_r_direct) ? S_DONE : S_WAIT;
            S_WAIT:  w_next = r_we ? S_WRITE : S_DONE;
            S_WRITE: w_next = S_DONE;
            default: w_next = S_IDLE;
        endcase
    end

    // Next values of the registered outputs, taken on the transition into each state.
    always_comb begin
        w_o_we    = 1'b0;
        w_o_addr  = mem_addr;
        w_o_wdata = mem_wdata;
        w_o_done  = '0;
        w_o_id    = '0;
        w_o_data  = '0;
        w_o_err   = 1'b0;
        case (r_state)
            S_IDLE: if (w_found) begin
                if (w_g_err) begin
                    w_o_done = L_ONE << w_gnt;
                    w_o_id   = w_gnt;
                    w_o_err  = 1'b1;
                end else begin
                    w_o_addr = {w_g_addr[ADDR_WIDTH-1:2], 2'b00};
                    if (req_we[w_gnt] && w_g_direct) begin
                        w_o_we    = 1'b1;
                        w_o_wdata = w_g_wdata << {w_g_addr[1:0], 3'b000};
                    end
                end
            end
            S_ISSUE: if (r_we && w_r_direct) begin
                w_o_done = L_ONE << r_id;
                w_o_id   = r_id;
            end
            S_WAIT: if (r_we) begin
                w_o_we    = 1'b1;
                w_o_wdata = w_merge;
            end else if (!w_cancel) begin
                w_o_done = L_ONE << r_id;
                w_o_id   = r_id;
                w_o_data = w_load;
            end
            S_WRITE: begin
                w_o_done = L_ONE << r_id;
                w_o_id   = r_id;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= '0;
            r_id      <= '0;
            r_we      <= 1'b0;
            r_signed  <= 1'b0;
            r_cancel  <= 1'b0;
            r_io      <= 1'b0;
            r_size    <= 2'b00;
            r_off     <= 2'b00;
            r_wdata   <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            resp_done <= '0;
            resp_id   <= '0;
            resp_data <= '0;
            resp_err  <= 1'b0;
        end else begin
            if (r_state == S_IDLE && w_found) begin
                r_ptr    <= (w_gnt == CH_W'(N_CH-1)) ? '0 : w_gnt + CH_W'(1);
                r_id     <= w_gnt;
                r_we     <= req_we[w_gnt];
                r_signed <= req_signed[w_gnt];
                r_size   <= w_g_size;
                r_off    <= w_g_addr[1:0];
                r_io     <= (w_g_addr[17:16] == 2'b11);
                r_wdata  <= w_g_wdata;
                r_cancel <= 1'b0;
            end else if ((r_state == S_ISSUE || r_state == S_WAIT) && !r_we && flush[r_id]) begin
                r_cancel <= 1'b1;
            end
            mem_we    <= w_o_we;
            mem_addr  <= w_o_addr;
            mem_wdata <= w_o_wdata;
            resp_done <= w_o_done;
            resp_id   <= w_o_id;
            resp_data <= w_o_data;
            resp_err  <= w_o_err;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter against a byte-level reference model
module tb_mem_arbiter;
    localparam int N = 3;
    localparam int AW = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    req_valid, req_we, req_signed, flush;
    logic [2*N-1:0]  req_size;
    logic [N*AW-1:0] req_addr;
    logic [N*32-1:0] req_wdata;
    logic [N-1:0]    resp_done;
    logic [1:0]      resp_id;
    logic [31:0]     resp_data;
    logic            resp_err;
    logic [AW-1:0]   mem_addr;
    logic            mem_we;
    logic [31:0]     mem_wdata, mem_rdata;

    mem_arbiter #(.N_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_size(req_size),
        .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata), .flush(flush),
        .resp_done(resp_done), .resp_id(resp_id), .resp_data(resp_data), .resp_err(resp_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    logic [31:0] mem [int];
    logic [7:0]  rb [int];
    logic        bd_we = 1'b0;
    int          bd_key = 0;
    logic [31:0] bd_data = '0;

    function automatic logic [31:0] mem_rd(input int key);
        return mem.exists(key) ? mem[key] : 32'h0;
    endfunction

    always @(posedge clk) begin
        mem_rdata <= mem_rd(int'(mem_addr >> 2));
        if (mem_we) mem[int'(mem_addr >> 2)] = mem_wdata;
        if (bd_we) mem[bd_key] = bd_data;
    end

    int n_vec = 0;
    int n_err = 0;
    int m_ptr = 0;
    logic        tr_we [1:13];
    logic [31:0] tr_addr [1:13];
    logic [31:0] tr_wd [1:13];
    logic [31:0] got_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] gb(input int a);
        return rb.exists(a) ? rb[a] : 8'h00;
    endfunction

    function automatic logic [31:0] ref_word(input int a);
        logic [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = gb((a & ~3) + i);
        return v;
    endfunction

    function automatic bit ref_err(input int sz, input int a);
        return (sz == 3) || (sz == 1 && a % 2 != 0) || (sz == 2 && a % 4 != 0);
    endfunction

    function automatic logic [31:0] ref_load(input int sz, input bit sg, input int a);
        int n;
        logic [31:0] v;
        n = 1 << sz;
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = gb(a + i);
        if (sg && n < 4 && v[8*n-1])
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic void ref_store(input int sz, input int a, input logic [31:0] wd);
        logic [31:0] w;
        if (a[17:16] == 2'b11) begin
            w = wd << (8 * (a % 4));
            for (int i = 0; i < 4; i++) rb[(a & ~3) + i] = w[8*i +: 8];
        end else begin
            for (int i = 0; i < (1 << sz); i++) rb[a + i] = wd[8*i +: 8];
        end
    endfunction

    function automatic int next_grant(input logic [N-1:0] act, input int ptr);
        for (int k = 0; k < N; k++)
            if (act[(ptr + k) % N]) return (ptr + k) % N;
        return -1;
    endfunction

    task automatic preload(input int a, input logic [31:0] d);
        bd_we = 1'b1;
        bd_key = a >> 2;
        bd_data = d;
        tick();
        bd_we = 1'b0;
        for (int i = 0; i < 4; i++) rb[(a & ~3) + i] = d[8*i +: 8];
    endtask

    task automatic set_req(input int ch, input bit we, input int sz, input bit sg, input int a,
                           input logic [31:0] wd);
        req_we[ch] = we;
        req_size[2*ch +: 2] = sz[1:0];
        req_signed[ch] = sg;
        req_addr[ch*AW +: AW] = a;
        req_wdata[ch*32 +: 32] = wd;
        req_valid[ch] = 1'b1;
    endtask

    // One request from an idle controller; returns once the controller is idle again.
    task automatic xact(input int ch, input bit we, input int sz, input bit sg, input int a,
                        input logic [31:0] wd, input string tag);
        int lat, exp_lat, nwr;
        bit err, io;
        logic [N-1:0] g_done;
        logic [31:0] g_id, g_err, exp_data;
        err = ref_err(sz, a);
        io = (a[17:16] == 2'b11);
        exp_lat = err ? 1 : (!we ? 3 : ((sz == 2 || io) ? 2 : 4));
        exp_data = (err || we) ? 32'h0 : ref_load(sz, sg, a);
        set_req(ch, we, sz, sg, a, wd);
        lat = 0; nwr = 0; g_done = '0; g_id = '0; g_err = '0; got_data = '0;
        for (int k = 1; k <= 12 && lat == 0; k++) begin
            tick();
            tr_we[k] = mem_we; tr_addr[k] = mem_addr; tr_wd[k] = mem_wdata;
            if (mem_we) nwr++;
            if (resp_done != '0) begin
                lat = k; g_done = resp_done; g_id = 32'(resp_id);
                got_data = resp_data; g_err = 32'(resp_err);
            end
        end
        req_valid[ch] = 1'b0;
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_done"}, 32'(g_done), 32'(1 << ch));
        chk({tag, "_id"}, g_id, ch);
        chk({tag, "_data"}, got_data, exp_data);
        chk({tag, "_err"}, g_err, 32'(err));
        chk({tag, "_writes"}, nwr, (err || !we) ? 0 : 1);
        if (!err && we) ref_store(sz, a, wd);
        chk({tag, "_memword"}, mem_rd(a >> 2), ref_word(a));
        m_ptr = (ch + 1) % N;
        tick();
    endtask

    initial begin
        logic [N-1:0] act;
        int g, lat, exp_lat;
        req_valid = '0; req_we = '0; req_signed = '0; flush = '0;
        req_size = '0; req_addr = '0; req_wdata = '0;

        tick(); tick();
        chk("rst_done", 32'(resp_done), 0);
        chk("rst_id", 32'(resp_id), 0);
        chk("rst_data", resp_data, 0);
        chk("rst_err", 32'(resp_err), 0);
        chk("rst_we", 32'(mem_we), 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        rst = 1'b1;
        tick();

        preload('h100, 32'hDEADBEEF);
        xact(0, 0, 2, 0, 'h100, 0, "ld_word");
        chk("ld_word_addr_t1", tr_addr[1], 32'h100);
        chk("ld_word_we_t1", 32'(tr_we[1]), 0);
        chk("ld_word_const", got_data, 32'hDEADBEEF);

        preload('h100, 32'h80FF0000);
        xact(1, 0, 0, 1, 'h103, 0, "ld_sbyte");
        chk("ld_sbyte_const", got_data, 32'hFFFFFF80);
        xact(2, 0, 0, 0, 'h103, 0, "ld_ubyte");
        chk("ld_ubyte_const", got_data, 32'h00000080);
        xact(0, 0, 1, 1, 'h102, 0, "ld_shalf");
        chk("ld_shalf_const", got_data, 32'hFFFF80FF);

        preload('h200, 32'h11223344);
        xact(1, 1, 0, 0, 'h201, 32'h000000AB, "st_rmw");
        chk("st_rmw_read_t1", 32'(tr_we[1]), 0);
        chk("st_rmw_addr_t1", tr_addr[1], 32'h200);
        chk("st_rmw_we_t3", 32'(tr_we[3]), 1);
        chk("st_rmw_wdata_t3", tr_wd[3], 32'h1122AB44);

        xact(2, 1, 0, 0, 'h30000, 32'h00000041, "st_io");
        chk("st_io_we_t1", 32'(tr_we[1]), 1);
        chk("st_io_wdata_t1", tr_wd[1], 32'h00000041);

        xact(0, 0, 1, 0, 'h101, 0, "err_half");
        xact(1, 1, 3, 0, 'h104, 32'h12345678, "err_size");

        // Continuous requesters: ch0/ch1, then ch2 joins.
        preload('h400, 32'hA0A0A0A0);
        preload('h404, 32'hB1B1B1B1);
        preload('h408, 32'hC2C2C2C2);
        for (int c = 0; c < N; c++) begin
            req_we[c] = 1'b0; req_size[2*c +: 2] = 2'b10; req_signed[c] = 1'b0;
            req_addr[c*AW +: AW] = 'h400 + 4*c;
        end
        act = 3'b011;
        req_valid = act;
        for (int n = 0; n < 12; n++) begin
            if (n == 6) begin
                act = 3'b111;
                req_valid = act;
            end
            g = next_grant(act, m_ptr);
            exp_lat = (n == 0) ? 3 : 4;
            lat = 0;
            for (int k = 1; k <= 8 && lat == 0; k++) begin
                tick();
                if (resp_done != '0) lat = k;
            end
            chk("rr_latency", lat, exp_lat);
            chk("rr_id", 32'(resp_id), g);
            chk("rr_data", resp_data, ref_load(2, 0, 'h400 + 4*g));
            m_ptr = (g + 1) % N;
        end
        req_valid = '0;
        tick();

        // Flush of a ch0 load while it waits for read data.
        set_req(0, 0, 2, 0, 'h100, 0);
        tick();
        chk("flush_t1_done", 32'(resp_done), 0);
        tick();
        flush[0] = 1'b1;
        tick();
        chk("flush_t3_done", 32'(resp_done), 0);
        chk("flush_t3_data", resp_data, 0);
        flush[0] = 1'b0;
        req_valid[0] = 1'b0;
        tick();
        chk("flush_t4_done", 32'(resp_done), 0);
        m_ptr = 1;
        xact(1, 0, 2, 0, 'h404, 0, "after_flush");

        // Reset while the read-modify-write is writing.
        set_req(2, 1, 0, 0, 'h202, 32'h00000077);
        tick(); tick(); tick();
        chk("rstw_we_before", 32'(mem_we), 1);
        rst = 1'b0;
        req_valid = '0;
        #1;
        chk("rstw_we", 32'(mem_we), 0);
        chk("rstw_addr", mem_addr, 0);
        chk("rstw_wdata", mem_wdata, 0);
        chk("rstw_done", 32'(resp_done), 0);
        chk("rstw_data", resp_data, 0);
        tick();
        rst = 1'b1;
        tick();
        chk("rstw_mem_unchanged", mem_rd('h200 >> 2), ref_word('h200));
        m_ptr = 0;

        for (int i = 0; i < 8; i++) preload('h400 + 4*i, $urandom);
        preload('h30010, $urandom);
        for (int i = 0; i < 40; i++) begin
            int ch, sz, a;
            bit we, sg;
            ch = $urandom_range(0, N-1);
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
            a = (($urandom_range(0, 3) == 0) ? 'h30010 : 'h400 + 4*$urandom_range(0, 7))
                + $urandom_range(0, 3);
            xact(ch, we, sz, sg, a, $urandom, "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
